// File: rtl/aes_loader_pkg.sv
// Shared definitions for the AES block loader.
// Contents:
//   state_t          FSM encoding LOAD / ISSUE / WAIT / DRAIN
//   WORDS_PER_BLOCK  32-bit words per 128-bit block
//   WORD_W, BLOCK_W  stream word width and block width
//   CORE_LAT_DEF     default minimum WAIT cycles before core_done is honoured
//   TIMEOUT_DEF      default WAIT cycles before the operation is abandoned
package aes_loader_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int CORE_LAT_DEF    = 13;
    localparam int TIMEOUT_DEF     = 64;

endpackage

// File: rtl/aes_block_loader_if.sv
// Word-stream bus between the loader and its upstream/downstream neighbours.
// Signals:
//   in_valid / in_ready / in_data            key + plaintext words into the loader
//   out_valid / out_ready / out_data / out_last  ciphertext words out of the loader
// Modports:
//   slave   the loader side (consumes input words, produces output words)
//   master  the environment side (produces input words, consumes output words)
//
// Handshake rule for both streams: a word transfers on a rising clock edge where
// valid && ready are both high. The producer keeps valid, data and last stable
// until that transfer happens; ready may change freely and never depends on a
// transfer completing in the same cycle.
interface aes_block_loader_if;
    import aes_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/word_shreg128.sv
// 4 x 32-bit shift register used for the key, plaintext and ciphertext buffers.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears contents)
//   scrub_i       synchronous clear; overrides every other operation
//   load_i        parallel load of load_data_i
//   load_data_i   128-bit parallel value
//   shift_in_i    shift left one word, word_i enters at the least significant word
//   word_i        serial input word
//   shift_out_i   shift left one word with zero fill
//   q_o           current contents; q_o[127:96] is the most significant word
module word_shreg128
    import aes_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               scrub_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] load_data_i,
    input  logic               shift_in_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               shift_out_i,
    output logic [BLOCK_W-1:0] q_o
);

    logic [BLOCK_W-1:0] buf_q;
    logic [BLOCK_W-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (scrub_i) begin
            buf_d = '0;
        end else if (load_i) begin
            buf_d = load_data_i;
        end else if (shift_in_i) begin
            buf_d = {buf_q[BLOCK_W-WORD_W-1:0], word_i};
        end else if (shift_out_i) begin
            buf_d = {buf_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign q_o = buf_q;

endmodule

// File: rtl/aes_block_loader.sv
// Stream wrapper around aes_core: collects key (4 words) and plaintext (4 words),
// pulses core_start once, waits for completion, then streams the ciphertext out as
// four words. Key, plaintext and ciphertext buffers are zeroed as soon as each has
// been consumed, on clear, on timeout and on reset.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus              word streams (slave side), see aes_block_loader_if
//   clear            abort the current block and scrub all buffers
//   core_start       one-cycle start pulse to aes_core (ISSUE)
//   core_key         key to the core, zero outside ISSUE
//   core_plaintext   plaintext to the core, zero outside ISSUE
//   core_ciphertext  ciphertext from the core
//   core_done        core completion level
//   busy             high in ISSUE, WAIT and DRAIN
//   timeout_err      one-cycle pulse in the WAIT cycle that abandons the operation
//   dbg_state        current FSM state
module aes_block_loader
    import aes_loader_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    aes_block_loader_if.slave   bus,
    input  logic                clear,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_key,
    output logic [BLOCK_W-1:0]  core_plaintext,
    input  logic [BLOCK_W-1:0]  core_ciphertext,
    input  logic                core_done,
    output logic                busy,
    output logic                timeout_err,
    output state_t              dbg_state
);

    localparam int WCNT_W = $clog2(TIMEOUT);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              clear_pend_q;

    logic [BLOCK_W-1:0] key_buf;
    logic [BLOCK_W-1:0] pt_buf;
    logic [BLOCK_W-1:0] ct_buf;

    logic in_ready;
    logic in_hs;
    logic out_hs;
    logic wait_done;
    logic wait_to;
    logic discard;
    logic abort_now;
    logic last_word;
    logic key_shift;
    logic pt_shift;
    logic kp_scrub;
    logic ct_load;
    logic ct_scrub;

    // in_ready is gated by rst so the stream is closed while reset is held and
    // opens in the first cycle after release.
    assign in_ready  = (state_q == S_LOAD) && !rst;
    assign in_hs     = bus.in_valid && in_ready;
    assign out_hs    = (state_q == S_DRAIN) && bus.out_ready;
    assign last_word = (cnt_q[1:0] == 2'd3);

    // Completion takes priority over timeout when both hold in the same cycle.
    assign wait_done = (state_q == S_WAIT) && core_done && (wcnt_q >= WCNT_W'(CORE_LAT));
    assign wait_to   = (state_q == S_WAIT) && !wait_done && (wcnt_q == WCNT_W'(TIMEOUT - 1));

    // A clear arriving in the final WAIT cycle is honoured just like a pending one.
    assign discard   = clear_pend_q || clear;
    assign abort_now = clear && ((state_q == S_LOAD) || (state_q == S_DRAIN));

    // Words 0-3 go to the key buffer, 4-7 to the plaintext buffer; a word that
    // handshakes together with clear is dropped.
    assign key_shift = in_hs && !clear && !cnt_q[2];
    assign pt_shift  = in_hs && !clear &&  cnt_q[2];

    // Key/plaintext are zeroed on the ISSUE->WAIT edge once the core has them.
    assign kp_scrub  = abort_now || (state_q == S_ISSUE) || wait_to;
    assign ct_load   = wait_done && !discard;
    assign ct_scrub  = abort_now || wait_to || (wait_done && discard) || (out_hs && last_word);

    word_shreg128 u_key_buf (
        .clk         (clk),
        .rst         (rst),
        .scrub_i     (kp_scrub),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_in_i  (key_shift),
        .word_i      (bus.in_data),
        .shift_out_i (1'b0),
        .q_o         (key_buf)
    );

    word_shreg128 u_pt_buf (
        .clk         (clk),
        .rst         (rst),
        .scrub_i     (kp_scrub),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_in_i  (pt_shift),
        .word_i      (bus.in_data),
        .shift_out_i (1'b0),
        .q_o         (pt_buf)
    );

    word_shreg128 u_ct_buf (
        .clk         (clk),
        .rst         (rst),
        .scrub_i     (ct_scrub),
        .load_i      (ct_load),
        .load_data_i (core_ciphertext),
        .shift_in_i  (1'b0),
        .word_i      ('0),
        .shift_out_i (out_hs),
        .q_o         (ct_buf)
    );

    // Lower ciphertext words only reach out_data by being shifted up.
    logic unused_ct_low;
    assign unused_ct_low = ^ct_buf[BLOCK_W-WORD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (clear) begin
                        cnt_q <= '0;
                    end else if (in_hs) begin
                        // cnt wraps 7 -> 0, leaving it ready for DRAIN.
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q      <= S_WAIT;
                    wcnt_q       <= '0;
                    // The core cannot be aborted, so a clear here only marks the result for discard.
                    clear_pend_q <= clear;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        state_q      <= discard ? S_LOAD : S_DRAIN;
                        cnt_q        <= '0;
                        wcnt_q       <= '0;
                        clear_pend_q <= 1'b0;
                    end else if (wait_to) begin
                        state_q      <= S_LOAD;
                        cnt_q        <= '0;
                        wcnt_q       <= '0;
                        clear_pend_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                        if (clear) begin
                            clear_pend_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (clear) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                    end else if (out_hs) begin
                        if (last_word) begin
                            state_q <= S_LOAD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_data  = (state_q == S_DRAIN) ? ct_buf[BLOCK_W-1 -: WORD_W] : '0;
    assign bus.out_last  = (state_q == S_DRAIN) && last_word;

    assign core_start     = (state_q == S_ISSUE);
    assign core_key       = (state_q == S_ISSUE) ? key_buf : '0;
    assign core_plaintext = (state_q == S_ISSUE) ? pt_buf  : '0;
    assign busy           = (state_q != S_LOAD);
    // Combinational so the pulse lands in the abandoning WAIT cycle itself;
    // it cannot be registered early because a same-cycle completion cancels it.
    assign timeout_err    = wait_to;
    assign dbg_state      = state_q;

endmodule
